piezo_tone_decoder: RTL and testbench



---
 rtl/piezo_tone_decoder_if.sv | 23 ++
 rtl/piezo_tone_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_piezo_tone_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/piezo_tone_decoder_if.sv
// Buzzer-side bus of the piezo tone decoder: the differential drive in, the
// classified alert and burst measurement out.
interface piezo_tone_decoder_if #(
    parameter int BURST_W = 28
);
    logic               piezo;
    logic               piezo_n;
    logic [2:0]         mode;
    logic               mode_vld;
    logic               burst_done;
    logic [BURST_W-1:0] burst_cyc;
    logic               diff_err;

    modport master (
        output piezo, piezo_n,
        input  mode, mode_vld, burst_done, burst_cyc, diff_err
    );

    modport slave (
        input  piezo, piezo_n,
        output mode, mode_vld, burst_done, burst_cyc, diff_err
    );
endinterface

// File: rtl/piezo_tone_decoder.sv
// Classifies the Segway buzzer alert from the tone half-period and measures burst length.
// Optional complement checking of piezo_n is enabled by defining PIEZO_DIFF_CHECK_EN.
module piezo_tone_decoder #(
    parameter int SCALE   = 0,
    parameter int CONFIRM = 4,
    parameter int BURST_W = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    piezo_tone_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_SILENT,
        S_ACQUIRE,
        S_LOCKED
    } state_e;

    typedef enum logic [2:0] {
        MODE_SILENT   = 3'd0,
        MODE_NORMAL   = 3'd1,
        MODE_BATT_LOW = 3'd2,
        MODE_OVR_SPD  = 3'd3,
        MODE_OVR_BATT = 3'd4
    } mode_e;

    localparam int CW = 20;
    localparam int MW = $clog2(CONFIRM + 1);
    localparam int SW = ((BURST_W > CW) ? BURST_W : CW) + 1;

    localparam logic [CW-1:0] SIL       = CW'(1 << (18 - SCALE));
    localparam logic [SW-1:0] BURST_MAX = SW'((64'd1 << BURST_W) - 64'd1);

    // Acceptance window of class k is H(k) +/- H(k)/8 with H(k) = 2^(k-SCALE).
    function automatic logic [CW-1:0] bound(input int k, input bit upper);
        int h;
        h = 1 << (k - SCALE);
        return upper ? CW'(h + h / 8) : CW'(h - h / 8);
    endfunction

    localparam logic [CW-1:0] LO1 = bound(16, 1'b0);
    localparam logic [CW-1:0] HI1 = bound(16, 1'b1);
    localparam logic [CW-1:0] LO2 = bound(15, 1'b0);
    localparam logic [CW-1:0] HI2 = bound(15, 1'b1);
    localparam logic [CW-1:0] LO3 = bound(14, 1'b0);
    localparam logic [CW-1:0] HI3 = bound(14, 1'b1);
    localparam logic [CW-1:0] LO4 = bound(13, 1'b0);
    localparam logic [CW-1:0] HI4 = bound(13, 1'b1);

    function automatic mode_e classify(input logic [CW-1:0] ivl);
        mode_e c;
        c = MODE_SILENT;
        if (ivl >= LO1 && ivl <= HI1) c = MODE_NORMAL;
        if (ivl >= LO2 && ivl <= HI2) c = MODE_BATT_LOW;
        if (ivl >= LO3 && ivl <= HI3) c = MODE_OVR_SPD;
        if (ivl >= LO4 && ivl <= HI4) c = MODE_OVR_BATT;
        return c;
    endfunction

    logic p_s1, p_s2, p_d;
    logic edge_det;

    // NOTE: flops take the async reset in the sensitivity list and update only
    // with non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_s1 <= 1'b0;
            p_s2 <= 1'b0;
            p_d  <= 1'b0;
        end else begin
            p_s1 <= bus.piezo;
            p_s2 <= p_s1;
            p_d  <= p_s2;
        end
    end

    assign edge_det = p_s2 ^ p_d;

`ifdef PIEZO_DIFF_CHECK_EN
    logic       pn_s1, pn_s2;
    logic [1:0] eq_run;
    logic       diff_err_q;

    // A one- or two-cycle overlap is synchronizer skew; a third is a wiring fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pn_s1      <= 1'b1;
            pn_s2      <= 1'b1;
            eq_run     <= 2'd0;
            diff_err_q <= 1'b0;
        end else begin
            pn_s1 <= bus.piezo_n;
            pn_s2 <= pn_s1;
            if (p_s2 == pn_s2) begin
                if (eq_run != 2'd3) eq_run <= eq_run + 2'd1;
                if (eq_run == 2'd2) diff_err_q <= 1'b1;
            end else begin
                eq_run <= 2'd0;
            end
        end
    end

    assign bus.diff_err = diff_err_q;
`else
    assign bus.diff_err = 1'b0;
`endif

    logic [CW-1:0] cnt;

    // Holds cycles since the last edge, so at the next edge it equals the interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= CW'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    state_e               state;
    mode_e                mode_q;
    mode_e                cur_class;
    logic [MW-1:0]        match_cnt;
    logic                 mode_vld_q;
    logic                 burst_done_q;
    logic [BURST_W-1:0]   burst_acc;
    logic [BURST_W-1:0]   burst_cyc_q;

    mode_e                cls;
    logic [MW-1:0]        match_nxt;
    logic [SW-1:0]        burst_sum;
    logic [BURST_W-1:0]   burst_nxt;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        cls       = classify(cnt);
        match_nxt = MW'(1);
        if (match_cnt != '0 && cls == cur_class) match_nxt = match_cnt + 1'b1;
        burst_sum = SW'(burst_acc) + SW'(cnt);
        burst_nxt = burst_sum[BURST_W-1:0];
        if (burst_sum > BURST_MAX) burst_nxt = BURST_MAX[BURST_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SILENT;
            mode_q       <= MODE_SILENT;
            cur_class    <= MODE_SILENT;
            match_cnt    <= '0;
            mode_vld_q   <= 1'b0;
            burst_done_q <= 1'b0;
            burst_acc    <= '0;
            burst_cyc_q  <= '0;
        end else begin
            mode_vld_q   <= 1'b0;
            burst_done_q <= 1'b0;
            // An edge always wins over a coincident timeout.
            if (edge_det) begin
                case (state)
                    S_SILENT: begin
                        state     <= S_ACQUIRE;
                        match_cnt <= '0;
                        burst_acc <= '0;
                    end
                    S_ACQUIRE: begin
                        burst_acc <= burst_nxt;
                        if (cls == MODE_SILENT) begin
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_nxt;
                            cur_class <= cls;
                            if (match_nxt == MW'(CONFIRM)) begin
                                state      <= S_LOCKED;
                                mode_q     <= cls;
                                mode_vld_q <= 1'b1;
                            end
                        end
                    end
                    S_LOCKED: begin
                        burst_acc <= burst_nxt;
                        if (cls == MODE_SILENT) begin
                            state     <= S_ACQUIRE;
                            match_cnt <= '0;
                        end else if (cls != cur_class) begin
                            state     <= S_ACQUIRE;
                            match_cnt <= MW'(1);
                            cur_class <= cls;
                        end
                    end
                    default: state <= S_SILENT;
                endcase
            end else if (cnt == SIL && state != S_SILENT) begin
                state        <= S_SILENT;
                mode_q       <= MODE_SILENT;
                burst_done_q <= 1'b1;
                burst_cyc_q  <= burst_acc;
            end
        end
    end

    assign bus.mode       = mode_q;
    assign bus.mode_vld   = mode_vld_q;
    assign bus.burst_done = burst_done_q;
    assign bus.burst_cyc  = burst_cyc_q;

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Directed bench for piezo_tone_decoder at SCALE=8 (H = 256/128/64/32, SIL = 1024).
module tb_piezo_tone_decoder;

    localparam int SCALE   = 8;
    localparam int CONFIRM = 4;
    localparam int BURST_W = 28;
    // Drive change -> registered output visible at the following negedge.
    localparam int LAT     = 3;
    localparam int SIL     = 1024;

`ifdef PIEZO_DIFF_CHECK_EN
    localparam int DIFF_EXP = 1;
`else
    localparam int DIFF_EXP = 0;
`endif

    typedef struct {
        int half;
        int edges;
        int exp_mode;
        int exp_vld;
        int exp_burst;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piezo_tone_decoder_if #(.BURST_W(BURST_W)) bus ();

    piezo_tone_decoder #(
        .SCALE  (SCALE),
        .CONFIRM(CONFIRM),
        .BURST_W(BURST_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    int done_cnt = 0;
    int vld_cyc  = 0;
    int done_cyc = 0;
    int last_edge_cyc = 0;
    int lock_edge_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.mode_vld) begin
            vld_cnt = vld_cnt + 1;
            vld_cyc = cyc;
        end
        if (bus.burst_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_edge();
        bus.piezo     = ~bus.piezo;
        bus.piezo_n   = ~bus.piezo;
        last_edge_cyc = cyc;
    endtask

    task automatic wait_timeout(input string tag, input int exp_burst);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < SIL + 200 && done_cnt == d0; i++) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_done_latency"}, done_cyc - last_edge_cyc, SIL + LAT);
        check({tag, "_burst_cyc"}, longint'(bus.burst_cyc), exp_burst);
        check({tag, "_mode_after_sil"}, longint'(bus.mode), 0);
        gap(1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int v0;
        v0 = vld_cnt;
        for (int e = 0; e < v.edges; e++) begin
            if (e > 0) gap(v.half);
            drive_edge();
            if (e == CONFIRM) lock_edge_cyc = cyc;
        end
        repeat (8) @(negedge clk);
        check({tag, "_mode"}, longint'(bus.mode), v.exp_mode);
        check({tag, "_vld_pulses"}, vld_cnt - v0, v.exp_vld);
        if (v.exp_vld != 0) check({tag, "_vld_latency"}, vld_cyc - lock_edge_cyc, LAT);
        wait_timeout(tag, v.exp_burst);
    endtask

    vec_t vecs[13];
    vec_t v6;

    initial begin
        int v0;

        vecs[0]  = '{256, 10, 1, 1, 2304};
        vecs[1]  = '{64,  20, 3, 1, 1216};
        vecs[2]  = '{36,  10, 4, 1, 324};
        vecs[3]  = '{40,  20, 0, 0, 760};
        vecs[4]  = '{128,  6, 2, 1, 640};
        vecs[5]  = '{28,   8, 4, 1, 196};
        vecs[6]  = '{37,  10, 0, 0, 333};
        vecs[7]  = '{288,  8, 1, 1, 2016};
        vecs[8]  = '{289,  6, 0, 0, 1445};
        vecs[9]  = '{224,  5, 1, 1, 896};
        vecs[10] = '{64,   4, 0, 0, 192};
        vecs[11] = '{32,   1, 0, 0, 0};
        vecs[12] = '{72,   6, 3, 1, 360};

        bus.piezo   = 1'b0;
        bus.piezo_n = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", longint'(bus.mode), 0);
        check("rst_mode_vld", longint'(bus.mode_vld), 0);
        check("rst_burst_done", longint'(bus.burst_done), 0);
        check("rst_burst_cyc", longint'(bus.burst_cyc), 0);
        check("rst_diff_err", longint'(bus.diff_err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        gap(4);

        for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Lock at 128, then switch to 32: mode holds until the relock.
        v0 = vld_cnt;
        for (int e = 0; e < 6; e++) begin
            if (e > 0) gap(128);
            drive_edge();
        end
        gap(10);
        check("sw_lock_mode", longint'(bus.mode), 2);
        check("sw_lock_pulses", vld_cnt - v0, 1);
        gap(22);
        drive_edge();
        gap(10);
        check("sw_held_mode", longint'(bus.mode), 2);
        gap(22);
        drive_edge();
        gap(32);
        drive_edge();
        gap(10);
        check("sw_pre_relock_mode", longint'(bus.mode), 2);
        check("sw_pre_relock_pulses", vld_cnt - v0, 1);
        gap(22);
        drive_edge();
        lock_edge_cyc = cyc;
        gap(10);
        check("sw_relock_mode", longint'(bus.mode), 4);
        check("sw_relock_pulses", vld_cnt - v0, 2);
        check("sw_relock_latency", vld_cyc - lock_edge_cyc, LAT);
        wait_timeout("sw", 768);

        // Reset while locked at mode 3 clears everything at once.
        for (int e = 0; e < 6; e++) begin
            if (e > 0) gap(64);
            drive_edge();
        end
        gap(10);
        check("mid_lock_mode", longint'(bus.mode), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mode", longint'(bus.mode), 0);
        check("mid_rst_mode_vld", longint'(bus.mode_vld), 0);
        check("mid_rst_burst_done", longint'(bus.burst_done), 0);
        check("mid_rst_burst_cyc", longint'(bus.burst_cyc), 0);
        check("mid_rst_diff_err", longint'(bus.diff_err), 0);
        bus.piezo   = 1'b0;
        bus.piezo_n = 1'b1;
        gap(3);
        rst_n = 1'b1;
        gap(3);
        v6 = '{64, 6, 3, 1, 320};
        run_vec("post_rst", v6);

        // Complement overlap: two cycles is skew, three is a fault.
        gap(2);
        bus.piezo_n = bus.piezo;
        gap(2);
        bus.piezo_n = ~bus.piezo;
        gap(6);
        check("diff_two_cycles", longint'(bus.diff_err), 0);
        bus.piezo_n = bus.piezo;
        gap(3);
        bus.piezo_n = ~bus.piezo;
        gap(6);
        check("diff_three_cycles", longint'(bus.diff_err), DIFF_EXP);
        run_vec("diff_traffic", v6);
        check("diff_sticky", longint'(bus.diff_err), DIFF_EXP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
